// File: rtl/vec_alu_seq_if.sv
// Request/result handshake bundle for the multi-beat vector ALU.
// The master side issues requests and consumes results. The slave side is the ALU.
interface vec_alu_seq_if #(
    parameter int VLEN = 128
) ();
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [1:0]      sew;
    logic [VLEN-1:0] vs1;
    logic [VLEN-1:0] vs2;
    logic [63:0]     scalar;
    logic            out_valid;
    logic            out_ready;
    logic [VLEN-1:0] vd;
    logic            out_err;

    modport master (
        output in_valid, op, sew, vs1, vs2, scalar, out_ready,
        input  in_ready, out_valid, vd, out_err
    );

    modport slave (
        input  in_valid, op, sew, vs1, vs2, scalar, out_ready,
        output in_ready, out_valid, vd, out_err
    );
endinterface

// File: rtl/vec_alu_seq.sv
// Multi-beat vector ALU: elementwise add/sub/mul (vector or scalar operand) and
// signed min/max/sum reductions, processing DPW bits of a VLEN-bit operation per cycle.
module vec_alu_seq #(
    parameter  int VLEN   = 128,
    parameter  int DPW    = 64,
    localparam int NBEATS = VLEN / DPW
) (
    input logic         clk,
    input logic         rst_n,
    vec_alu_seq_if.slave bus
);
    localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state, state_nxt;
    logic [BW-1:0]   beat;
    logic [3:0]      op_q;
    logic [1:0]      sew_q;
    logic [VLEN-1:0] vs1_q, vs2_q, vd_q;
    logic [63:0]     scalar_q, acc, acc_nxt;
    logic            err_q;
    logic [DPW-1:0]  beat_res;
    logic [63:0]     mask;

    function automatic logic [63:0] sew_mask(input logic [1:0] s);
        return (s == 2'd3) ? '1 : ((64'd1 << (8 << s)) - 64'd1);
    endfunction

    wire last_beat  = (beat == BW'(NBEATS - 1));
    wire is_red     = (op_q >= 4'd6) && (op_q <= 4'd8);
    wire use_scalar = (op_q == 4'd1) || (op_q == 4'd3) || (op_q == 4'd5);

    // Beat datapath. Elements are extracted by shift-and-mask so that one loop
    // serves every SEW, and reductions keep a sign-extended 64-bit accumulator.
    always_comb begin
        int             w;
        int             n_el;
        logic [DPW-1:0] a_slice, b_slice;
        logic [63:0]    x, y, r, sx, top;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        w        = 8 << sew_q;
        n_el     = DPW >> (3 + int'(sew_q));
        mask     = sew_mask(sew_q);
        top      = mask ^ (mask >> 1);
        a_slice  = vs1_q[beat*DPW +: DPW];
        b_slice  = vs2_q[beat*DPW +: DPW];
        beat_res = '0;
        acc_nxt  = acc;
        x        = '0;
        y        = '0;
        r        = '0;
        sx       = '0;
        for (int e = 0; e < DPW / 8; e++) begin
            if (e < n_el) begin
                x  = 64'(a_slice >> (w * e)) & mask;
                y  = use_scalar ? (scalar_q & mask) : (64'(b_slice >> (w * e)) & mask);
                sx = (|(x & top)) ? (x | ~mask) : x;
                case (op_q)
                    4'd0, 4'd1: r = x + y;
                    4'd2, 4'd3: r = x - y;
                    4'd4, 4'd5: r = x * y;
                    default:    r = '0;
                endcase
                beat_res = beat_res | (DPW'(r & mask) << (w * e));
                case (op_q)
                    4'd6:    if ($signed(sx) < $signed(acc_nxt)) acc_nxt = sx;
                    4'd7:    if ($signed(sx) > $signed(acc_nxt)) acc_nxt = sx;
                    4'd8:    acc_nxt = acc_nxt + x;
                    default: acc_nxt = acc_nxt;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = BUSY;
            end
            BUSY: if (last_beat) state_nxt = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the operand
    // registers are plain flops, so they take the async reset like everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat     <= '0;
            op_q     <= '0;
            sew_q    <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            scalar_q <= '0;
            acc      <= '0;
            vd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_q     <= bus.op;
                    sew_q    <= bus.sew;
                    vs1_q    <= bus.vs1;
                    vs2_q    <= bus.vs2;
                    scalar_q <= bus.scalar;
                    beat     <= '0;
                    case (bus.op)
                        4'd6:    acc <= sew_mask(bus.sew) >> 1;
                        4'd7:    acc <= ~(sew_mask(bus.sew) >> 1);
                        default: acc <= '0;
                    endcase
                end
                BUSY: begin
                    beat <= beat + 1'b1;
                    acc  <= acc_nxt;
                    if (!is_red) vd_q[beat*DPW +: DPW] <= beat_res;
                    if (last_beat) begin
                        err_q <= (op_q > 4'd8);
                        if (is_red) vd_q <= VLEN'(acc_nxt & mask);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vd      = vd_q;
    assign bus.out_err = err_q;
endmodule
